bin_to_bcd_serial: RTL
======================

Name: bin_to_bcd_serial

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). Processes one input bit per clock.
- Sits directly upstream of the seven-segment decoders. Each 4-bit digit of its output drives one decoder's BCD input.
- Start/busy/done handshake, so a controller or counter can request a conversion and latch the result for display.

Parameters:
- WIDTH, 8, bit width of the binary input. Conversion takes WIDTH shift cycles.
- DIGITS, 3, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1; the defaults cover 0..255.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled on the rising edge while idle.
- bin  input  WIDTH  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has just been updated.
- bcd  output  4*DIGITS  packed BCD result. Units in [3:0], tens in [7:4], hundreds in [11:8], and so on. Registered; holds its value between conversions.

Behaviour:
- Reset:
  - Asserting reset_n low immediately forces state IDLE, busy=0, done=0, bcd=0.
  - The internal shift register and bit counter are also cleared.
  - Takes effect asynchronously and aborts any conversion in progress; no partial result reaches bcd.
  - Release is synchronous to the next clock edge.
- States: IDLE, SHIFT.
- IDLE:
  - busy=0.
  - On an edge with start=1:
    - capture bin into the binary shift register;
    - clear the BCD scratch register;
    - load bit counter = WIDTH;
    - go to SHIFT, busy=1.
  - start=0: remain in IDLE.
- SHIFT, on each edge:
  - For every scratch digit >= 5, add 3 to that digit. Digits are evaluated in parallel, combinationally, before the shift.
  - Shift {scratch, binary} left by 1; the binary register MSB enters the scratch LSB.
  - Decrement the counter.
  - On the edge where the counter reaches 0 (the WIDTH-th shift edge):
    - load bcd with the final scratch value;
    - set done=1 for exactly one cycle;
    - busy=0;
    - return to IDLE.
- Latency: start sampled at edge E. bcd is updated and done goes high at edge E+WIDTH (8 cycles by default). busy is high for edges E..E+WIDTH-1.
- Throughput: back-to-back is allowed. start=1 while done=1 (state already IDLE) is accepted on that edge, giving one result every WIDTH+1 cycles.
- start while busy=1 is ignored: not queued, and bin is not re-captured.
- bin changing during SHIFT has no effect; only the value captured at acceptance is used.
- The scratch register is 4*DIGITS bits. No digit ever exceeds 9 after the add-3 correction. With legal parameters there is no overflow and no overflow flag.
- done is a registered output and never asserts in the same cycle as busy.

Test Plan:
- Reset then idle: reset_n=0 mid-simulation -> busy=0, done=0, bcd=12'h000 immediately. No done pulse after release without start.
- bin=8'd0, start pulse -> done exactly 8 cycles after the accepting edge, bcd=12'h000.
- bin=8'd255 -> bcd=12'h255. bin=8'd99 -> 12'h099. bin=8'd128 -> 12'h128. bin=8'd10 -> 12'h010. Each has done width of 1 cycle and busy high for 8 cycles.
- Back-to-back: start=1 held continuously with bin=8'd42 then 8'd7 -> bcd=12'h042, then 12'h007 nine cycles later; done pulses spaced 9 cycles apart.
- Start and bin changes while busy: accept 8'd200, then pulse start with bin=8'd13 at cycle 3 -> result 12'h200, no second done pulse.
- Reset mid-conversion: accept 8'd77, reset_n=0 at cycle 4 -> bcd remains 12'h000 and no done pulse. After release, convert 8'd77 -> 12'h077.

Source files
------------

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start request in idle captures bin; WIDTH shift edges later the packed BCD
// result is loaded into bcd and done pulses for one cycle.
module bin_to_bcd_serial #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned ScrW = 4 * DIGITS;

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e             r_state, w_state_d;
   logic [WIDTH-1:0]   r_bin,   w_bin_d;
   logic [ScrW-1:0]    r_scr,   w_scr_d;
   logic [CntW-1:0]    r_cnt,   w_cnt_d;
   logic [ScrW-1:0]    r_bcd,   w_bcd_d;
   logic               r_done,  w_done_d;
   logic [ScrW-1:0]    w_adj;
   logic [ScrW-1:0]    w_scr_shift;

   // State register: all sequential state, cleared asynchronously.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_bin   <= '0;
         r_scr   <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_bin   <= w_bin_d;
         r_scr   <= w_scr_d;
         r_cnt   <= w_cnt_d;
         r_bcd   <= w_bcd_d;
         r_done  <= w_done_d;
      end
   end

   // Add-3 correction on every digit >= 5, all digits in parallel, then the shift.
   always_comb begin
      w_adj = r_scr;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (r_scr[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
         end
      end
      w_scr_shift = {w_adj[ScrW-2:0], r_bin[WIDTH-1]};
   end

   // Next-state logic: accept in idle, shift while converting, publish on the last shift.
   always_comb begin
      w_state_d = r_state;
      w_bin_d   = r_bin;
      w_scr_d   = r_scr;
      w_cnt_d   = r_cnt;
      w_bcd_d   = r_bcd;
      w_done_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_bin_d   = bin;
               w_scr_d   = '0;
               w_cnt_d   = CntW'(WIDTH);
               w_state_d = StShift;
            end
         end
         StShift: begin
            w_bin_d = {r_bin[WIDTH-2:0], 1'b0};
            w_scr_d = w_scr_shift;
            w_cnt_d = r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
               w_bcd_d   = w_scr_shift;
               w_done_d  = 1'b1;
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs: busy decoded from state, done and bcd straight from registers.
   always_comb begin
      busy = (r_state == StShift);
      done = r_done;
      bcd  = r_bcd;
   end

endmodule
